// File: rtl/ctrl_ext_exmem.sv
// ctrl_ext_exmem
//   Decode-and-pipeline slice of the 5-stage MIPS core:
//   - main control decoder (ID stage, combinational)
//   - 16->32-bit immediate extender (ID stage, combinational, driven by
//     the decoder's own EXTOp)
//   - EX/MEM pipeline register (async active-low reset, write enable)
//
// Ports
//   clk, rst                : clock / async active-low reset (EX/MEM only)
//   OpCode, Funct           : instr[31:26], instr[5:0]
//   jump, RegDst, Branch,
//   MemR, Mem2R, MemW, RegW,
//   Alusrc, EXTOp, Aluctrl  : decoded control toward ID/EX
//   Imm16 / Imm32           : raw / extended immediate
//   EX_MEM_WR               : 1 = load EX/MEM on the edge, 0 = hold
//   *_IN / *_OUT            : EX/MEM fields (NPC, ALU result, store data,
//                             dest reg, MEMR/MEMW/REGW/MEM2R)
module ctrl_ext_exmem (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  OpCode,
   input  logic [5:0]  Funct,
   output logic [1:0]  jump,
   output logic        RegDst,
   output logic [1:0]  Branch,
   output logic        MemR,
   output logic        Mem2R,
   output logic        MemW,
   output logic        RegW,
   output logic        Alusrc,
   output logic [1:0]  EXTOp,
   output logic [4:0]  Aluctrl,
   input  logic [15:0] Imm16,
   output logic [31:0] Imm32,
   input  logic        EX_MEM_WR,
   input  logic [31:0] NPC_IN,
   output logic [31:0] NPC_OUT,
   input  logic [31:0] ALU_C_IN,
   output logic [31:0] ALU_C_OUT,
   input  logic [31:0] RT_DATA_IN,
   output logic [31:0] RT_DATA_OUT,
   input  logic [4:0]  reg_rd_in,
   output logic [4:0]  reg_rd_out,
   input  logic        MEMR_IN,
   output logic        MEMR_OUT,
   input  logic        MEMW_IN,
   output logic        MEMW_OUT,
   input  logic        REGW_IN,
   output logic        REGW_OUT,
   input  logic        MEM2R_IN,
   output logic        MEM2R_OUT
);

   typedef enum logic [4:0] {
      ALU_ADD   = 5'd0,
      ALU_SUB   = 5'd1,
      ALU_AND   = 5'd2,
      ALU_OR    = 5'd3,
      ALU_XOR   = 5'd4,
      ALU_NOR   = 5'd5,
      ALU_SLT   = 5'd6,
      ALU_SLTU  = 5'd7,
      ALU_SLL   = 5'd8,
      ALU_SRL   = 5'd9,
      ALU_SRA   = 5'd10,
      ALU_PASSB = 5'd11
   } alu_op_e;

   typedef enum logic [1:0] {
      EXT_ZERO = 2'b00,
      EXT_SIGN = 2'b01,
      EXT_LUI  = 2'b10
   } ext_op_e;

   // ---------------------------------------------------------------
   // Main control decoder. Everything defaults to 0 so unknown
   // opcodes/functs fall out as a bubble.
   // ---------------------------------------------------------------
   always_comb begin
      jump    = 2'b00;
      RegDst  = 1'b0;
      Branch  = 2'b00;
      MemR    = 1'b0;
      Mem2R   = 1'b0;
      MemW    = 1'b0;
      RegW    = 1'b0;
      Alusrc  = 1'b0;
      EXTOp   = EXT_ZERO;
      Aluctrl = ALU_ADD;

      unique case (OpCode)
         6'b000000: begin
            // R-type: only listed functs assert RegW
            RegW = 1'b1;
            unique case (Funct)
               6'b100000, 6'b100001: Aluctrl = ALU_ADD;
               6'b100010, 6'b100011: Aluctrl = ALU_SUB;
               6'b100100:            Aluctrl = ALU_AND;
               6'b100101:            Aluctrl = ALU_OR;
               6'b100110:            Aluctrl = ALU_XOR;
               6'b100111:            Aluctrl = ALU_NOR;
               6'b101010:            Aluctrl = ALU_SLT;
               6'b101011:            Aluctrl = ALU_SLTU;
               6'b000000:            Aluctrl = ALU_SLL;
               6'b000010:            Aluctrl = ALU_SRL;
               6'b000011:            Aluctrl = ALU_SRA;
               6'b001000: begin
                  RegW = 1'b0;
                  jump = 2'b11;
               end
               default:              RegW = 1'b0;
            endcase
         end
         6'b001000, 6'b001001: begin
            RegW = 1'b1; RegDst = 1'b1; Alusrc = 1'b1;
            EXTOp = EXT_SIGN; Aluctrl = ALU_ADD;
         end
         6'b001010: begin
            RegW = 1'b1; RegDst = 1'b1; Alusrc = 1'b1;
            EXTOp = EXT_SIGN; Aluctrl = ALU_SLT;
         end
         6'b001011: begin
            RegW = 1'b1; RegDst = 1'b1; Alusrc = 1'b1;
            EXTOp = EXT_SIGN; Aluctrl = ALU_SLTU;
         end
         6'b001100: begin
            RegW = 1'b1; RegDst = 1'b1; Alusrc = 1'b1;
            Aluctrl = ALU_AND;
         end
         6'b001101: begin
            RegW = 1'b1; RegDst = 1'b1; Alusrc = 1'b1;
            Aluctrl = ALU_OR;
         end
         6'b001110: begin
            RegW = 1'b1; RegDst = 1'b1; Alusrc = 1'b1;
            Aluctrl = ALU_XOR;
         end
         6'b001111: begin
            RegW = 1'b1; RegDst = 1'b1; Alusrc = 1'b1;
            EXTOp = EXT_LUI; Aluctrl = ALU_PASSB;
         end
         6'b100011: begin
            MemR = 1'b1; Mem2R = 1'b1; RegW = 1'b1; RegDst = 1'b1;
            Alusrc = 1'b1; EXTOp = EXT_SIGN; Aluctrl = ALU_ADD;
         end
         6'b101011: begin
            MemW = 1'b1; Alusrc = 1'b1; EXTOp = EXT_SIGN; Aluctrl = ALU_ADD;
         end
         6'b000100: begin
            Branch = 2'b01; EXTOp = EXT_SIGN; Aluctrl = ALU_SUB;
         end
         6'b000101: begin
            Branch = 2'b10; EXTOp = EXT_SIGN; Aluctrl = ALU_SUB;
         end
         6'b000010: begin
            Branch = 2'b11; jump = 2'b01;
         end
         // jal: the link write is performed outside this block, so RegW stays 0
         6'b000011: begin
            Branch = 2'b11; jump = 2'b10;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------
   // Immediate extender; EXTOp 11 behaves as sign-extend.
   // ---------------------------------------------------------------
   always_comb begin
      unique case (EXTOp)
         EXT_ZERO: Imm32 = {16'h0000, Imm16};
         EXT_LUI:  Imm32 = {Imm16, 16'h0000};
         default:  Imm32 = {{16{Imm16[15]}}, Imm16};
      endcase
   end

   // ---------------------------------------------------------------
   // EX/MEM pipeline register. A cleared register is a bubble.
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         NPC_OUT     <= '0;
         ALU_C_OUT   <= '0;
         RT_DATA_OUT <= '0;
         reg_rd_out  <= '0;
         MEMR_OUT    <= 1'b0;
         MEMW_OUT    <= 1'b0;
         REGW_OUT    <= 1'b0;
         MEM2R_OUT   <= 1'b0;
      end else if (EX_MEM_WR) begin
         NPC_OUT     <= NPC_IN;
         ALU_C_OUT   <= ALU_C_IN;
         RT_DATA_OUT <= RT_DATA_IN;
         reg_rd_out  <= reg_rd_in;
         MEMR_OUT    <= MEMR_IN;
         MEMW_OUT    <= MEMW_IN;
         REGW_OUT    <= REGW_IN;
         MEM2R_OUT   <= MEM2R_IN;
      end
   end

endmodule

// File: tb/tb_ctrl_ext_exmem.sv
// Testbench for ctrl_ext_exmem: table-driven decode/extend vectors plus
// directed EX/MEM load, hold and asynchronous reset sequences.
module tb_ctrl_ext_exmem;

   logic        clk;
   logic        rst;
   logic [5:0]  OpCode, Funct;
   logic [1:0]  jump, Branch, EXTOp;
   logic        RegDst, MemR, Mem2R, MemW, RegW, Alusrc;
   logic [4:0]  Aluctrl;
   logic [15:0] Imm16;
   logic [31:0] Imm32;
   logic        EX_MEM_WR;
   logic [31:0] NPC_IN, NPC_OUT, ALU_C_IN, ALU_C_OUT, RT_DATA_IN, RT_DATA_OUT;
   logic [4:0]  reg_rd_in, reg_rd_out;
   logic        MEMR_IN, MEMR_OUT, MEMW_IN, MEMW_OUT;
   logic        REGW_IN, REGW_OUT, MEM2R_IN, MEM2R_OUT;

   int unsigned tests;
   int unsigned fails;

   ctrl_ext_exmem dut (
      .clk(clk), .rst(rst),
      .OpCode(OpCode), .Funct(Funct),
      .jump(jump), .RegDst(RegDst), .Branch(Branch),
      .MemR(MemR), .Mem2R(Mem2R), .MemW(MemW), .RegW(RegW),
      .Alusrc(Alusrc), .EXTOp(EXTOp), .Aluctrl(Aluctrl),
      .Imm16(Imm16), .Imm32(Imm32),
      .EX_MEM_WR(EX_MEM_WR),
      .NPC_IN(NPC_IN), .NPC_OUT(NPC_OUT),
      .ALU_C_IN(ALU_C_IN), .ALU_C_OUT(ALU_C_OUT),
      .RT_DATA_IN(RT_DATA_IN), .RT_DATA_OUT(RT_DATA_OUT),
      .reg_rd_in(reg_rd_in), .reg_rd_out(reg_rd_out),
      .MEMR_IN(MEMR_IN), .MEMR_OUT(MEMR_OUT),
      .MEMW_IN(MEMW_IN), .MEMW_OUT(MEMW_OUT),
      .REGW_IN(REGW_IN), .REGW_OUT(REGW_OUT),
      .MEM2R_IN(MEM2R_IN), .MEM2R_OUT(MEM2R_OUT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // decode word: {jump, RegDst, Branch, MemR, Mem2R, MemW, RegW, Alusrc, EXTOp, Aluctrl}
   typedef struct {
      string       name;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [15:0] imm;
      logic [16:0] dec;
      logic [31:0] imm32;
   } vec_t;

   function automatic logic [16:0] mk(input logic [1:0] j, input logic rd,
                                      input logic [1:0] br, input logic mr,
                                      input logic m2r, input logic mw,
                                      input logic rw, input logic as,
                                      input logic [1:0] ext, input logic [4:0] alu);
      return {j, rd, br, mr, m2r, mw, rw, as, ext, alu};
   endfunction

   function automatic vec_t v(input string n, input logic [5:0] op, input logic [5:0] fn,
                              input logic [15:0] imm, input logic [16:0] dec,
                              input logic [31:0] imm32);
      vec_t r;
      r.name = n; r.op = op; r.fn = fn; r.imm = imm; r.dec = dec; r.imm32 = imm32;
      return r;
   endfunction

   function automatic logic [104:0] reg_word(input logic [31:0] npc, input logic [31:0] alu,
                                             input logic [31:0] rt, input logic [4:0] rd,
                                             input logic mr, input logic mw,
                                             input logic rw, input logic m2r);
      return {npc, alu, rt, rd, mr, mw, rw, m2r};
   endfunction

   task automatic check_reg(input string n, input logic [104:0] exp);
      logic [104:0] act;
      act = {NPC_OUT, ALU_C_OUT, RT_DATA_OUT, reg_rd_out,
             MEMR_OUT, MEMW_OUT, REGW_OUT, MEM2R_OUT};
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic drive_in(input logic [31:0] npc, input logic [31:0] alu,
                           input logic [31:0] rt, input logic [4:0] rd,
                           input logic mr, input logic mw,
                           input logic rw, input logic m2r);
      NPC_IN = npc; ALU_C_IN = alu; RT_DATA_IN = rt; reg_rd_in = rd;
      MEMR_IN = mr; MEMW_IN = mw; REGW_IN = rw; MEM2R_IN = m2r;
   endtask

   vec_t vecs[$];
   logic [16:0] act_dec;

   initial begin
      tests = 0;
      fails = 0;

      //            name      op         fn         imm       j     rd    br    mr    m2r   mw    rw    as    ext    alu       imm32
      vecs.push_back(v("lw",    6'b100011, 6'b000000, 16'hFFFC, mk(2'b00,1'b1,2'b00,1'b1,1'b1,1'b0,1'b1,1'b1,2'b01,5'd0),  32'hFFFFFFFC));
      vecs.push_back(v("ori",   6'b001101, 6'b000000, 16'h8001, mk(2'b00,1'b1,2'b00,1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,5'd3),  32'h00008001));
      vecs.push_back(v("lui",   6'b001111, 6'b000000, 16'h8001, mk(2'b00,1'b1,2'b00,1'b0,1'b0,1'b0,1'b1,1'b1,2'b10,5'd11), 32'h80010000));
      vecs.push_back(v("beq",   6'b000100, 6'b000000, 16'h0010, mk(2'b00,1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,5'd1),  32'h00000010));
      vecs.push_back(v("bne",   6'b000101, 6'b000000, 16'h8000, mk(2'b00,1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,5'd1),  32'hFFFF8000));
      vecs.push_back(v("j",     6'b000010, 6'b000000, 16'h9234, mk(2'b01,1'b0,2'b11,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,5'd0),  32'h00009234));
      vecs.push_back(v("jal",   6'b000011, 6'b000000, 16'hABCD, mk(2'b10,1'b0,2'b11,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,5'd0),  32'h0000ABCD));
      vecs.push_back(v("jr",    6'b000000, 6'b001000, 16'hF000, mk(2'b11,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,5'd0),  32'h0000F000));
      vecs.push_back(v("sub",   6'b000000, 6'b100010, 16'h0000, mk(2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,5'd1),  32'h00000000));
      vecs.push_back(v("sra",   6'b000000, 6'b000011, 16'h80C3, mk(2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,5'd10), 32'h000080C3));
      vecs.push_back(v("sll",   6'b000000, 6'b000000, 16'h0000, mk(2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,5'd8),  32'h00000000));
      vecs.push_back(v("sltu",  6'b000000, 6'b101011, 16'h0000, mk(2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,5'd7),  32'h00000000));
      vecs.push_back(v("nor",   6'b000000, 6'b100111, 16'h0000, mk(2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,5'd5),  32'h00000000));
      vecs.push_back(v("badfn", 6'b000000, 6'b111111, 16'h8001, mk(2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,5'd0),  32'h00008001));
      vecs.push_back(v("badop", 6'b111111, 6'b100000, 16'h8001, mk(2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,5'd0),  32'h00008001));
      vecs.push_back(v("sw",    6'b101011, 6'b000000, 16'h8000, mk(2'b00,1'b0,2'b00,1'b0,1'b0,1'b1,1'b0,1'b1,2'b01,5'd0),  32'hFFFF8000));
      vecs.push_back(v("slti",  6'b001010, 6'b000000, 16'h7FFF, mk(2'b00,1'b1,2'b00,1'b0,1'b0,1'b0,1'b1,1'b1,2'b01,5'd6),  32'h00007FFF));
      vecs.push_back(v("andi",  6'b001100, 6'b000000, 16'hFFFF, mk(2'b00,1'b1,2'b00,1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,5'd2),  32'h0000FFFF));
      vecs.push_back(v("xori",  6'b001110, 6'b000000, 16'h8000, mk(2'b00,1'b1,2'b00,1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,5'd4),  32'h00008000));
      vecs.push_back(v("addiu", 6'b001001, 6'b000000, 16'hFFFF, mk(2'b00,1'b1,2'b00,1'b0,1'b0,1'b0,1'b1,1'b1,2'b01,5'd0),  32'hFFFFFFFF));

      rst = 1'b0;
      EX_MEM_WR = 1'b0;
      OpCode = '0; Funct = '0; Imm16 = '0;
      drive_in(32'hDEAD_BEEF, 32'hCAFE_0001, 32'h5555_AAAA, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1);

      // reset state, including across an edge with load requested
      #2;
      check_reg("reset_async", '0);
      EX_MEM_WR = 1'b1;
      @(posedge clk); #1;
      check_reg("reset_hold_edge", '0);

      // combinational decode/extend table
      foreach (vecs[i]) begin
         OpCode = vecs[i].op;
         Funct  = vecs[i].fn;
         Imm16  = vecs[i].imm;
         #1;
         act_dec = {jump, RegDst, Branch, MemR, Mem2R, MemW, RegW, Alusrc, EXTOp, Aluctrl};
         tests++;
         if (act_dec !== vecs[i].dec) begin
            fails++;
            $display("FAIL dec_%s: got %b expected %b", vecs[i].name, act_dec, vecs[i].dec);
         end
         tests++;
         if (Imm32 !== vecs[i].imm32) begin
            fails++;
            $display("FAIL imm_%s: got %h expected %h", vecs[i].name, Imm32, vecs[i].imm32);
         end
      end

      // release reset, first load on the first enabled edge
      @(negedge clk);
      rst = 1'b1;
      EX_MEM_WR = 1'b1;
      drive_in(32'h0000_0040, 32'h0000_1234, 32'h0BAD_F00D, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      check_reg("no_load_before_edge", '0);
      @(posedge clk); #1;
      check_reg("load", reg_word(32'h0000_0040, 32'h0000_1234, 32'h0BAD_F00D, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0));

      // hold for 3 edges with new inputs presented
      @(negedge clk);
      EX_MEM_WR = 1'b0;
      drive_in(32'hFFFF_FFFF, 32'h8765_4321, 32'h1111_2222, 5'd17, 1'b1, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check_reg($sformatf("hold_%0d", k),
                   reg_word(32'h0000_0040, 32'h0000_1234, 32'h0BAD_F00D, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0));
      end

      // second load picks up the new inputs
      @(negedge clk);
      EX_MEM_WR = 1'b1;
      @(posedge clk); #1;
      check_reg("load2", reg_word(32'hFFFF_FFFF, 32'h8765_4321, 32'h1111_2222, 5'd17, 1'b1, 1'b1, 1'b0, 1'b1));

      // asynchronous reset mid-cycle, then an enabled edge while still in reset
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_reg("async_clear", '0);
      @(posedge clk); #1;
      check_reg("reset_beats_load", '0);

      // recovery after reset
      @(negedge clk);
      rst = 1'b1;
      drive_in(32'h0000_1000, 32'h0000_0004, 32'h0000_0008, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
      @(posedge clk); #1;
      check_reg("reload", reg_word(32'h0000_1000, 32'h0000_0004, 32'h0000_0008, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
